// File: rtl/alu_pkg.sv
// Shared ALU control definitions: ALUConf codes, branch-condition codes, MIPS
// opcode/funct values, operand-select encodings and the decoded control word.
package alu_pkg;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_SLT = 5'b00111;
    localparam logic [4:0] ALU_NOR = 5'b01100;
    localparam logic [4:0] ALU_XOR = 5'b01101;
    localparam logic [4:0] ALU_SRL = 5'b10000;
    localparam logic [4:0] ALU_SRA = 5'b11000;
    localparam logic [4:0] ALU_SLL = 5'b11001;

    localparam logic [5:0] BR_NONE = 6'h00;
    localparam logic [5:0] BR_EQ   = 6'h04;
    localparam logic [5:0] BR_NE   = 6'h11;
    localparam logic [5:0] BR_GEZ  = 6'h12;
    localparam logic [5:0] BR_GTZ  = 6'h13;
    localparam logic [5:0] BR_LEZ  = 6'h14;
    localparam logic [5:0] BR_LTZ  = 6'h15;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    localparam logic [1:0] OP1_RS    = 2'd0;
    localparam logic [1:0] OP1_SHAMT = 2'd1;
    localparam logic [1:0] OP1_C16   = 2'd2;

    localparam logic [1:0] OP2_RT   = 2'd0;
    localparam logic [1:0] OP2_SEXT = 2'd1;
    localparam logic [1:0] OP2_ZEXT = 2'd2;

    typedef struct packed {
        logic [4:0]  alu_conf;
        logic [5:0]  alu_opcode;
        logic        alu_sign;
        logic [1:0]  op1_sel;
        logic [1:0]  op2_sel;
        logic [31:0] imm32;
        logic [4:0]  shamt;
        logic        illegal;
    } ctrl_word_t;

    function automatic logic [31:0] sext16(input logic signed [15:0] v);
        logic signed [31:0] w;
        w = 32'(v);
        return w;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational MIPS instruction decoder producing the ALU control word.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_word_t  ctrl
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    logic       unused_rs;

    assign opcode    = instr[31:26];
    assign funct     = instr[5:0];
    assign rt        = instr[20:16];
    assign unused_rs = ^instr[25:21];

    always_comb begin
        ctrl          = '0;
        ctrl.alu_conf = ALU_ADD;
        ctrl.shamt    = instr[10:6];
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  begin ctrl.alu_conf = ALU_ADD; ctrl.alu_sign = 1'b1; end
                    FN_ADDU: ctrl.alu_conf = ALU_ADD;
                    FN_SUB:  begin ctrl.alu_conf = ALU_SUB; ctrl.alu_sign = 1'b1; end
                    FN_SUBU: ctrl.alu_conf = ALU_SUB;
                    FN_AND:  ctrl.alu_conf = ALU_AND;
                    FN_OR:   ctrl.alu_conf = ALU_OR;
                    FN_XOR:  ctrl.alu_conf = ALU_XOR;
                    FN_NOR:  ctrl.alu_conf = ALU_NOR;
                    FN_SLT:  begin ctrl.alu_conf = ALU_SLT; ctrl.alu_sign = 1'b1; end
                    FN_SLTU: ctrl.alu_conf = ALU_SLT;
                    // The ALU shifts In2 by In1[4:0]: shamt or rs arrives on operand 1
                    FN_SLL:  begin ctrl.alu_conf = ALU_SLL; ctrl.op1_sel = OP1_SHAMT; end
                    FN_SRL:  begin ctrl.alu_conf = ALU_SRL; ctrl.op1_sel = OP1_SHAMT; end
                    FN_SRA:  begin ctrl.alu_conf = ALU_SRA; ctrl.op1_sel = OP1_SHAMT; end
                    FN_SLLV: ctrl.alu_conf = ALU_SLL;
                    FN_SRLV: ctrl.alu_conf = ALU_SRL;
                    FN_SRAV: ctrl.alu_conf = ALU_SRA;
                    FN_JR:   ctrl.alu_conf = ALU_ADD;
                    default: ctrl.illegal = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                ctrl.alu_conf = ALU_SUB;
                ctrl.alu_sign = 1'b1;
                if (rt == RT_BLTZ)      ctrl.alu_opcode = BR_LTZ;
                else if (rt == RT_BGEZ) ctrl.alu_opcode = BR_GEZ;
                else                    ctrl.illegal = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                ctrl.alu_conf = ALU_SUB;
                ctrl.alu_sign = 1'b1;
                ctrl.op2_sel  = OP2_RT;
                case (opcode)
                    OP_BEQ:  ctrl.alu_opcode = BR_EQ;
                    OP_BNE:  ctrl.alu_opcode = BR_NE;
                    OP_BLEZ: ctrl.alu_opcode = BR_LEZ;
                    default: ctrl.alu_opcode = BR_GTZ;
                endcase
            end
            OP_ADDI:  begin ctrl.alu_conf = ALU_ADD; ctrl.alu_sign = 1'b1; ctrl.op2_sel = OP2_SEXT; end
            OP_ADDIU: begin ctrl.alu_conf = ALU_ADD; ctrl.op2_sel = OP2_SEXT; end
            OP_SLTI:  begin ctrl.alu_conf = ALU_SLT; ctrl.alu_sign = 1'b1; ctrl.op2_sel = OP2_SEXT; end
            OP_SLTIU: begin ctrl.alu_conf = ALU_SLT; ctrl.op2_sel = OP2_SEXT; end
            OP_ANDI:  begin ctrl.alu_conf = ALU_AND; ctrl.op2_sel = OP2_ZEXT; end
            OP_ORI:   begin ctrl.alu_conf = ALU_OR;  ctrl.op2_sel = OP2_ZEXT; end
            OP_XORI:  begin ctrl.alu_conf = ALU_XOR; ctrl.op2_sel = OP2_ZEXT; end
            // lui is imm << 16, realised as a shift by the constant operand 16
            OP_LUI:   begin ctrl.alu_conf = ALU_SLL; ctrl.op1_sel = OP1_C16; ctrl.op2_sel = OP2_ZEXT; end
            OP_LW, OP_SW: begin ctrl.alu_conf = ALU_ADD; ctrl.op2_sel = OP2_SEXT; end
            OP_J, OP_JAL: ctrl.alu_conf = ALU_ADD;
            default: ctrl.illegal = 1'b1;
        endcase

        if (ctrl.illegal) begin
            ctrl.alu_conf   = ALU_ADD;
            ctrl.alu_opcode = BR_NONE;
            ctrl.alu_sign   = 1'b0;
            ctrl.op1_sel    = OP1_RS;
            ctrl.op2_sel    = OP2_RT;
        end

        // Zero-extend only when the ALU will use the zero-extended form; otherwise
        // present the sign-extended value (branch offsets, lw/sw, arithmetic)
        if (ctrl.op2_sel == OP2_ZEXT) ctrl.imm32 = {16'h0000, instr[15:0]};
        else                          ctrl.imm32 = sext16(instr[15:0]);
    end

endmodule

// File: rtl/alu_ctrl_issue.sv
// ID/EX boundary register for the ALU control word: valid/ready handshake,
// flush kill and a saturating count of accepted illegal instructions.
module alu_ctrl_issue
    import alu_pkg::*;
#(
    parameter int ILLEGAL_CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    input  logic [31:0]              in_pc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4:0]               alu_conf,
    output logic [5:0]               alu_opcode,
    output logic                     alu_sign,
    output logic [1:0]               op1_sel,
    output logic [1:0]               op2_sel,
    output logic [31:0]              imm32,
    output logic [4:0]               shamt,
    output logic [31:0]              out_pc,
    output logic                     illegal,
    output logic [ILLEGAL_CNT_W-1:0] illegal_cnt
);

    function automatic logic [ILLEGAL_CNT_W-1:0] sat_inc(input logic [ILLEGAL_CNT_W-1:0] v);
        return (&v) ? v : v + ILLEGAL_CNT_W'(1);
    endfunction

    ctrl_word_t               ctrl_p0;
    ctrl_word_t               ctrl_p1;
    logic                     vld_p1;
    logic [31:0]              pc_p1;
    logic [ILLEGAL_CNT_W-1:0] ill_cnt_p1;
    logic                     load;

    alu_ctrl_decode u_decode (
        .instr (instr),
        .ctrl  (ctrl_p0)
    );

    assign in_ready = !vld_p1 || out_ready;
    assign load     = in_valid && in_ready && !flush;

    // p0 -> p1: decoded word captured at the ID/EX boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            ctrl_p1    <= '0;
            pc_p1      <= '0;
            ill_cnt_p1 <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (load) begin
            vld_p1  <= 1'b1;
            ctrl_p1 <= ctrl_p0;
            pc_p1   <= in_pc;
            if (ctrl_p0.illegal) ill_cnt_p1 <= sat_inc(ill_cnt_p1);
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid   = vld_p1;
    assign alu_conf    = ctrl_p1.alu_conf;
    assign alu_opcode  = ctrl_p1.alu_opcode;
    assign alu_sign    = ctrl_p1.alu_sign;
    assign op1_sel     = ctrl_p1.op1_sel;
    assign op2_sel     = ctrl_p1.op2_sel;
    assign imm32       = ctrl_p1.imm32;
    assign shamt       = ctrl_p1.shamt;
    assign illegal     = ctrl_p1.illegal;
    assign out_pc      = pc_p1;
    assign illegal_cnt = ill_cnt_p1;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Scoreboard bench for alu_ctrl_issue: table-driven reference decode, queue of
// expected words, and a monitor that checks every word EX accepts.
module tb_alu_ctrl_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] in_pc = '0;
    logic        in_ready, out_valid, alu_sign, illegal;
    logic [4:0]  alu_conf, shamt;
    logic [5:0]  alu_opcode;
    logic [1:0]  op1_sel, op2_sel;
    logic [31:0] imm32, out_pc;
    logic [7:0]  illegal_cnt;

    alu_ctrl_issue #(.ILLEGAL_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .alu_conf(alu_conf), .alu_opcode(alu_opcode),
        .alu_sign(alu_sign), .op1_sel(op1_sel), .op2_sel(op2_sel), .imm32(imm32),
        .shamt(shamt), .out_pc(out_pc), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  conf;
        logic [5:0]  bc;
        logic        sign;
        logic [1:0]  op1;
        logic [1:0]  op2;
        logic [31:0] imm;
        logic [4:0]  sh;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    logic exp_vld = 1'b0;
    int   exp_cnt = 0;

    // Reference tables: R-type by funct, other opcodes by opcode
    logic       r_ok[64];
    logic [4:0] r_conf[64];
    logic       r_sign[64];
    logic [1:0] r_op1[64];
    logic       i_ok[64];
    logic [4:0] i_conf[64];
    logic       i_sign[64];
    logic [1:0] i_op1[64];
    logic [1:0] i_op2[64];
    logic [5:0] i_bc[64];

    task automatic r_set(input int fn, input logic [4:0] c, input logic s, input logic [1:0] o1);
        r_ok[fn] = 1'b1; r_conf[fn] = c; r_sign[fn] = s; r_op1[fn] = o1;
    endtask

    task automatic i_set(input int op, input logic [4:0] c, input logic s, input logic [1:0] o1,
                         input logic [1:0] o2, input logic [5:0] bc);
        i_ok[op] = 1'b1; i_conf[op] = c; i_sign[op] = s; i_op1[op] = o1; i_op2[op] = o2; i_bc[op] = bc;
    endtask

    task automatic init_tables();
        for (int k = 0; k < 64; k++) begin
            r_ok[k] = 1'b0; r_conf[k] = '0; r_sign[k] = 1'b0; r_op1[k] = '0;
            i_ok[k] = 1'b0; i_conf[k] = '0; i_sign[k] = 1'b0; i_op1[k] = '0; i_op2[k] = '0; i_bc[k] = '0;
        end
        r_set('h20, 5'b00000, 1, 0); r_set('h21, 5'b00000, 0, 0);
        r_set('h22, 5'b00110, 1, 0); r_set('h23, 5'b00110, 0, 0);
        r_set('h24, 5'b00010, 0, 0); r_set('h25, 5'b00001, 0, 0);
        r_set('h26, 5'b01101, 0, 0); r_set('h27, 5'b01100, 0, 0);
        r_set('h2A, 5'b00111, 1, 0); r_set('h2B, 5'b00111, 0, 0);
        r_set('h00, 5'b11001, 0, 1); r_set('h02, 5'b10000, 0, 1); r_set('h03, 5'b11000, 0, 1);
        r_set('h04, 5'b11001, 0, 0); r_set('h06, 5'b10000, 0, 0); r_set('h07, 5'b11000, 0, 0);
        r_set('h08, 5'b00000, 0, 0);
        i_set('h08, 5'b00000, 1, 0, 1, 6'h00); i_set('h09, 5'b00000, 0, 0, 1, 6'h00);
        i_set('h0A, 5'b00111, 1, 0, 1, 6'h00); i_set('h0B, 5'b00111, 0, 0, 1, 6'h00);
        i_set('h0C, 5'b00010, 0, 0, 2, 6'h00); i_set('h0D, 5'b00001, 0, 0, 2, 6'h00);
        i_set('h0E, 5'b01101, 0, 0, 2, 6'h00); i_set('h0F, 5'b11001, 0, 2, 2, 6'h00);
        i_set('h23, 5'b00000, 0, 0, 1, 6'h00); i_set('h2B, 5'b00000, 0, 0, 1, 6'h00);
        i_set('h04, 5'b00110, 1, 0, 0, 6'h04); i_set('h05, 5'b00110, 1, 0, 0, 6'h11);
        i_set('h06, 5'b00110, 1, 0, 0, 6'h14); i_set('h07, 5'b00110, 1, 0, 0, 6'h13);
        i_set('h02, 5'b00000, 0, 0, 0, 6'h00); i_set('h03, 5'b00000, 0, 0, 0, 6'h00);
    endtask

    function automatic exp_t model(input logic [31:0] ins);
        exp_t e;
        int   op, fn, rt;
        op = int'(ins[31:26]); fn = int'(ins[5:0]); rt = int'(ins[20:16]);
        e.conf = '0; e.bc = '0; e.sign = 1'b0; e.op1 = '0; e.op2 = '0; e.ill = 1'b0;
        e.sh = ins[10:6]; e.pc = '0;
        if (op == 0 && r_ok[fn]) begin
            e.conf = r_conf[fn]; e.sign = r_sign[fn]; e.op1 = r_op1[fn];
        end else if (op != 0 && i_ok[op]) begin
            e.conf = i_conf[op]; e.sign = i_sign[op]; e.op1 = i_op1[op]; e.op2 = i_op2[op]; e.bc = i_bc[op];
        end else if (op == 1 && rt < 2) begin
            e.conf = 5'b00110; e.sign = 1'b1; e.bc = (rt == 0) ? 6'h15 : 6'h12;
        end else begin
            e.ill = 1'b1;
        end
        if (e.op2 == 2) e.imm = {16'h0, ins[15:0]};
        else            e.imm = {{16{ins[15]}}, ins[15:0]};
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_empty: got out_valid=1, required no pending word");
            end else begin
                e = sbq.pop_front();
                chk("alu_conf", alu_conf, e.conf);
                chk("alu_opcode", alu_opcode, e.bc);
                chk("alu_sign", alu_sign, e.sign);
                chk("op1_sel", op1_sel, e.op1);
                chk("op2_sel", op2_sel, e.op2);
                chk("imm32", imm32, e.imm);
                chk("shamt", shamt, e.sh);
                chk("out_pc", out_pc, e.pc);
                chk("illegal", illegal, e.ill);
            end
        end
    end

    // One cycle: drive just after posedge, check and advance the model at negedge
    task automatic step(input logic v, input logic [31:0] ins, input logic fl, input logic rdy);
        exp_t e;
        logic ld;
        in_valid = v; instr = ins; in_pc = $urandom; flush = fl; out_ready = rdy;
        @(negedge clk);
        chk("out_valid", out_valid, exp_vld);
        chk("in_ready", in_ready, !exp_vld || rdy);
        chk("illegal_cnt", illegal_cnt, exp_cnt);
        ld = v && (!exp_vld || rdy) && !fl;
        if (fl) begin
            if (exp_vld && !rdy) sbq.delete(0);
            exp_vld = 1'b0;
        end else if (ld) begin
            e = model(ins);
            e.pc = in_pc;
            sbq.push_back(e);
            exp_vld = 1'b1;
            if (e.ill && exp_cnt < 255) exp_cnt++;
        end else if (rdy) begin
            exp_vld = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    logic [5:0]  op_pool[18] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
                                 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    logic [5:0]  fn_pool[17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                                 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation still running at time limit, required $finish");
        $fatal(1);
    end

    initial begin : driver
        logic [31:0] ins;
        logic [90:0] snap;
        init_tables();

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fields", {alu_conf, alu_opcode, alu_sign, op1_sel, op2_sel, imm32, shamt, out_pc, illegal}, 0);
        chk("rst_cnt", illegal_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        step(1, 32'h00221820, 0, 1);
        chk("add_conf", alu_conf, 5'b00000); chk("add_sign", alu_sign, 1);
        step(1, 32'h00021843, 0, 1);
        chk("sra_conf", alu_conf, 5'b11000); chk("sra_op1", op1_sel, 1); chk("sra_shamt", shamt, 1);
        step(1, 32'h3C011234, 0, 1);
        chk("lui_conf", alu_conf, 5'b11001); chk("lui_op1", op1_sel, 2);
        chk("lui_op2", op2_sel, 2); chk("lui_imm", imm32, 32'h00001234);
        step(1, 32'h14220003, 0, 1);
        chk("bne_conf", alu_conf, 5'b00110); chk("bne_code", alu_opcode, 6'h11);
        step(1, 32'h04200002, 0, 1);
        chk("bltz_code", alu_opcode, 6'h15);
        step(1, 32'h04210002, 0, 1);
        chk("bgez_code", alu_opcode, 6'h12);
        step(1, 32'h2841FFFF, 0, 1);
        chk("slti_imm", imm32, 32'hFFFFFFFF); chk("slti_sign", alu_sign, 1);

        // Backpressure: hold three cycles with a new instruction waiting
        step(1, 32'h00622022, 0, 0);
        snap = {alu_conf, alu_opcode, alu_sign, op1_sel, op2_sel, imm32, shamt, out_pc, illegal};
        for (int k = 0; k < 3; k++) begin
            step(1, 32'h30A5F0F0, 0, 0);
            chk("hold_stable", {alu_conf, alu_opcode, alu_sign, op1_sel, op2_sel, imm32, shamt, out_pc, illegal}, snap);
        end
        step(1, 32'h30A5F0F0, 0, 1);
        chk("after_hold_conf", alu_conf, 5'b00010);
        step(0, 32'h0, 0, 1);

        // Flush kills an incoming illegal word without counting it
        step(1, 32'hFC000000, 1, 1);
        step(1, 32'hFC000000, 0, 1);
        chk("illegal_flag", illegal, 1);
        for (int k = 0; k < 260; k++) step(1, 32'hFC000000, 0, 1);
        step(0, 32'h0, 0, 1);
        chk("cnt_saturated", illegal_cnt, 8'hFF);

        // Asynchronous reset while a word is held
        step(1, 32'h00221820, 0, 1);
        step(1, 32'h00221820, 0, 0);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_fields", {alu_conf, alu_opcode, alu_sign, op1_sel, op2_sel, imm32, shamt, out_pc, illegal}, 0);
        chk("arst_cnt", illegal_cnt, 0);
        chk("arst_in_ready", in_ready, 1);
        sbq.delete();
        exp_vld = 1'b0;
        exp_cnt = 0;
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 800; k++) begin
            ins = $urandom;
            if ($urandom_range(0, 4) != 0) ins[31:26] = op_pool[$urandom_range(0, 17)];
            if (ins[31:26] == 6'h00 && $urandom_range(0, 3) != 0) ins[5:0] = fn_pool[$urandom_range(0, 16)];
            if (ins[31:26] == 6'h01) ins[20:16] = 5'($urandom_range(0, 3));
            step($urandom_range(0, 3) != 0, ins, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
        end
        step(0, 32'h0, 0, 1);
        step(0, 32'h0, 0, 1);
        chk("sb_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
